// File: rtl/hwloop_controller.sv
`default_nettype none
// ==== hwloop_controller : PC vs loop-end compare, registered loop-back jump and ====
// ==== counter-decrement pulses for the hardware-loop register file   (rev 1.0)  ====
module hwloop_controller #(
  parameter int N_REGSET = 2,
  parameter int ADDR_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               current_pc_i,
  input  logic                            pc_valid_i,
  input  logic                            flush_i,
  input  logic [N_REGSET-1:0][ADDR_W-1:0] hwlp_start_addr_i,
  input  logic [N_REGSET-1:0][ADDR_W-1:0] hwlp_end_addr_i,
  input  logic [N_REGSET-1:0][31:0]       hwlp_counter_i,
  output logic                            hwlp_jump_o,
  output logic [ADDR_W-1:0]               hwlp_targ_addr_o,
  output logic [N_REGSET-1:0]             hwlp_dec_cnt_o
);

  localparam int CNT_W = 32;

  logic [N_REGSET-1:0][CNT_W-1:0] eff_cnt;
  logic [N_REGSET-1:0]            hit;
  logic [N_REGSET-1:0]            dec_d;
  logic                           jump_d;
  logic [ADDR_W-1:0]              targ_d;
  logic                           evaluate;
  logic                           accept;

  assign accept = pc_valid_i && !flush_i;

  generate
    for (genvar i = 0; i < N_REGSET; i++) begin : g_loop
      // A decrement issued last cycle is not yet visible in the register file.
      assign eff_cnt[i] = (hwlp_dec_cnt_o[i] && (hwlp_counter_i[i] != '0))
                          ? hwlp_counter_i[i] - CNT_W'(1)
                          : hwlp_counter_i[i];
      assign hit[i] = accept && (current_pc_i == hwlp_end_addr_i[i]) && (eff_cnt[i] != '0);
    end
  endgenerate

  // Lower index has priority; an exiting loop lets the next outer loop see the same end.
  always_comb begin
    dec_d    = '0;
    jump_d   = 1'b0;
    targ_d   = hwlp_targ_addr_o;
    evaluate = 1'b1;
    for (int i = 0; i < N_REGSET; i++) begin
      if (evaluate && hit[i]) begin
        dec_d[i] = 1'b1;
        if (eff_cnt[i] > CNT_W'(1)) begin
          jump_d   = 1'b1;
          targ_d   = hwlp_start_addr_i[i];
          evaluate = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwlp_jump_o      <= 1'b0;
      hwlp_targ_addr_o <= '0;
      hwlp_dec_cnt_o   <= '0;
    end else begin
      hwlp_jump_o      <= jump_d;
      hwlp_targ_addr_o <= targ_d;
      hwlp_dec_cnt_o   <= dec_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hwloop_controller.sv
`default_nettype none
// Bench for hwloop_controller: directed scenarios then randomized segments, checked
// against a model that tracks remaining loop iterations architecturally.
module tb_hwloop_controller;
  localparam int N = 2;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [W-1:0]        current_pc_i;
  logic                pc_valid_i;
  logic                flush_i;
  logic [N-1:0][W-1:0] start_a;
  logic [N-1:0][W-1:0] end_a;
  logic [N-1:0][31:0]  rf_cnt;
  logic                hwlp_jump_o;
  logic [W-1:0]        hwlp_targ_addr_o;
  logic [N-1:0]        hwlp_dec_cnt_o;

  logic                ld_req;
  logic [N-1:0][31:0]  ld_val;
  int                  tests = 0;
  int                  fails = 0;
  int unsigned         mc [N];
  logic [W-1:0]        targ_hold;

  always #5 clk = ~clk;

  hwloop_controller #(.N_REGSET(N), .ADDR_W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .current_pc_i     (current_pc_i),
    .pc_valid_i       (pc_valid_i),
    .flush_i          (flush_i),
    .hwlp_start_addr_i(start_a),
    .hwlp_end_addr_i  (end_a),
    .hwlp_counter_i   (rf_cnt),
    .hwlp_jump_o      (hwlp_jump_o),
    .hwlp_targ_addr_o (hwlp_targ_addr_o),
    .hwlp_dec_cnt_o   (hwlp_dec_cnt_o)
  );

  // Register-file stand-in: applies each decrement pulse at the end of the cycle it is high.
  always @(posedge clk) begin
    if (ld_req) rf_cnt <= ld_val;
    else begin
      for (int i = 0; i < N; i++)
        if (hwlp_dec_cnt_o[i]) rf_cnt[i] <= rf_cnt[i] - 32'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ID-stage cycle; the model consumes an iteration the moment the end is reached.
  task automatic step(input logic [W-1:0] pc, input logic v, input logic f);
    logic [N-1:0] e_dec;
    logic         e_jump;
    current_pc_i = pc;
    pc_valid_i   = v;
    flush_i      = f;
    e_dec  = '0;
    e_jump = 1'b0;
    if (v && !f) begin
      for (int i = 0; i < N; i++) begin
        if (pc == end_a[i] && mc[i] != 0) begin
          e_dec[i] = 1'b1;
          mc[i]    = mc[i] - 1;
          if (mc[i] != 0) begin
            e_jump    = 1'b1;
            targ_hold = start_a[i];
            break;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("jump", {63'd0, hwlp_jump_o}, {63'd0, e_jump});
    check("dec",  {62'd0, hwlp_dec_cnt_o}, {62'd0, e_dec});
    check("targ", {32'd0, hwlp_targ_addr_o}, {32'd0, targ_hold});
  endtask

  task automatic load(input logic [W-1:0] s0, input logic [W-1:0] e0, input int unsigned c0,
                      input logic [W-1:0] s1, input logic [W-1:0] e1, input int unsigned c1);
    step(32'hFFFF_FFF0, 1'b0, 1'b0);
    start_a[0] = s0; end_a[0] = e0;
    start_a[1] = s1; end_a[1] = e1;
    ld_val[0]  = c0; ld_val[1] = c1;
    mc[0] = c0; mc[1] = c1;
    ld_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Idle one cycle so the last pulse lands, then compare the register file to the model.
  task automatic settle();
    step(32'hFFFF_FFF0, 1'b0, 1'b0);
    check("cnt0", {32'd0, rf_cnt[0]}, {32'd0, mc[0]});
    check("cnt1", {32'd0, rf_cnt[1]}, {32'd0, mc[1]});
  endtask

  initial begin
    logic [W-1:0] s0, s1, e0, e1, pc;
    int unsigned  r;
    rst = 1'b1;
    current_pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
    start_a = '0; end_a = '0; ld_val = '0; ld_req = 1'b0;
    targ_hold = '0;
    repeat (2) @(negedge clk);
    check("rst_jump", {63'd0, hwlp_jump_o}, 64'd0);
    check("rst_dec",  {62'd0, hwlp_dec_cnt_o}, 64'd0);
    check("rst_targ", {32'd0, hwlp_targ_addr_o}, 64'd0);
    rst = 1'b0;

    // Simple three-iteration loop with a four-instruction body
    load(32'h100, 32'h10C, 3, 32'h0, 32'h9990000, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h100, 1'b1, 1'b0);
      step(32'h104, 1'b1, 1'b0);
      step(32'h108, 1'b1, 1'b0);
      step(32'h10C, 1'b1, 1'b0);
    end
    settle();

    // One-instruction body: back-to-back hits rely on in-flight compensation
    load(32'h200, 32'h200, 2, 32'h0, 32'h9990000, 0);
    repeat (3) step(32'h200, 1'b1, 1'b0);
    settle();

    // Nested loops sharing an end address: inner exits, outer jumps
    load(32'h2F0, 32'h300, 1, 32'h2E0, 32'h300, 5);
    step(32'h300, 1'b1, 1'b0);
    settle();

    // Inner loop has priority and blocks the outer loop
    load(32'h2F0, 32'h300, 4, 32'h2E0, 32'h300, 5);
    step(32'h300, 1'b1, 1'b0);
    settle();

    // Flush kills a hit; a stalled hit fires once it is accepted
    load(32'h100, 32'h10C, 3, 32'h0, 32'h9990000, 0);
    step(32'h10C, 1'b1, 1'b1);
    repeat (3) step(32'h10C, 1'b0, 1'b0);
    step(32'h10C, 1'b1, 1'b0);
    step(32'h104, 1'b1, 1'b0);
    settle();

    // Asynchronous reset while a jump is being presented
    load(32'h100, 32'h10C, 3, 32'h0, 32'h9990000, 0);
    step(32'h10C, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_jump", {63'd0, hwlp_jump_o}, 64'd0);
    check("arst_dec",  {62'd0, hwlp_dec_cnt_o}, 64'd0);
    check("arst_targ", {32'd0, hwlp_targ_addr_o}, 64'd0);
    targ_hold = '0;
    mc[0] = mc[0] + 1;  // the in-flight decrement never reaches the register file
    pc_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("arst_cnt0", {32'd0, rf_cnt[0]}, {32'd0, mc[0]});
    load(32'h100, 32'h10C, 0, 32'h80, 32'h20C, 0);
    step(32'h10C, 1'b1, 1'b0);
    settle();

    // Randomized segments
    for (int seg = 0; seg < 24; seg++) begin
      s0 = $urandom & 32'hFFFF_FFFC;
      s1 = $urandom & 32'hFFFF_FFFC;
      e0 = s0 + 32'($urandom_range(0, 7) * 4);
      e1 = ($urandom_range(0, 1) == 0) ? e0 : s1 + 32'($urandom_range(0, 7) * 4);
      load(s0, e0, $urandom_range(0, 4), s1, e1, $urandom_range(0, 4));
      for (int k = 0; k < 16; k++) begin
        r  = $urandom_range(0, 9);
        pc = (r < 4) ? e0 : (r < 7) ? e1 : ($urandom & 32'hFFFF_FFFC);
        step(pc, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
      end
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
